// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBlank,
      StShow
   } scan_state_e;

   localparam logic [6:0]  SEG_OFF = 7'b0000000;
   localparam int unsigned BCD_W   = 4;

endpackage

// File: rtl/seven_seg_scan_ctrl_decoder.sv
// BCD to 7-segment decoder, segments packed {g,f,e,d,c,b,a}, active-high.
module seven_segment_decoder
   import seven_seg_pkg::*;
(
   input  logic [BCD_W-1:0] i_bcd,
   output logic [6:0]       o_seg
);

   always_comb begin
      o_seg = SEG_OFF;
      case (i_bcd)
         4'd0:    o_seg = 7'b0111111;
         4'd1:    o_seg = 7'b0000110;
         4'd2:    o_seg = 7'b1011011;
         4'd3:    o_seg = 7'b1001111;
         4'd4:    o_seg = 7'b1100110;
         4'd5:    o_seg = 7'b1101101;
         4'd6:    o_seg = 7'b1111101;
         4'd7:    o_seg = 7'b0000111;
         4'd8:    o_seg = 7'b1111111;
         4'd9:    o_seg = 7'b1101111;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller driving one digit at a time with a blanking gap.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_enable,
   input  logic                        i_load,
   input  logic [BCD_W*NUM_DIGITS-1:0] i_value_in,
   input  logic                        i_lz_blank_en,
   output logic [NUM_DIGITS-1:0]       o_anode,
   output logic [6:0]                  o_segments,
   output logic                        o_load_pending,
   output logic                        o_frame_done
);

   localparam int unsigned CntW = $clog2(PRESCALE);
   localparam int unsigned IdxW = $clog2(NUM_DIGITS);
   localparam int unsigned ValW = BCD_W * NUM_DIGITS;

   localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
   localparam logic [CntW-1:0] ShowLast  = CntW'(PRESCALE - BLANK_CYCLES - 1);
   localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

   scan_state_e           r_state, w_state_nxt;
   logic [CntW-1:0]       r_cnt, w_cnt_nxt;
   logic [IdxW-1:0]       r_idx, w_idx_nxt;
   logic [ValW-1:0]       r_shadow, w_shadow_nxt;
   logic [ValW-1:0]       r_pending, w_pending_nxt;
   logic                  r_load_pending, w_load_pending_nxt;
   logic [NUM_DIGITS-1:0] r_anode, w_anode_nxt;
   logic [6:0]            r_segments, w_segments_nxt;

   logic                  w_frame_end;
   logic                  w_capture;
   logic [BCD_W-1:0]      w_digit;
   logic                  w_digit_blank;
   logic                  w_zero_above;
   logic [6:0]            w_dec_seg;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_frame_end = 1'b0;
      if (!i_enable) begin
         w_state_nxt = StIdle;
         w_cnt_nxt   = '0;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            StIdle: begin
               w_state_nxt = StBlank;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
            StBlank: begin
               if (r_cnt == BlankLast) begin
                  w_state_nxt = StShow;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CntW'(1);
               end
            end
            StShow: begin
               if (r_cnt == ShowLast) begin
                  w_state_nxt = StBlank;
                  w_cnt_nxt   = '0;
                  if (r_idx == IdxLast) begin
                     w_idx_nxt   = '0;
                     w_frame_end = 1'b1;
                  end else begin
                     w_idx_nxt = r_idx + IdxW'(1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CntW'(1);
               end
            end
            default: begin
               w_state_nxt = StIdle;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // Shadow only changes on IDLE exit or at a frame boundary, so a frame never tears.
   assign w_capture = (r_state == StIdle && i_enable) || w_frame_end;

   always_comb begin
      w_shadow_nxt       = r_shadow;
      w_pending_nxt      = r_pending;
      w_load_pending_nxt = r_load_pending;
      if (w_capture) begin
         if (i_load) begin
            w_shadow_nxt = i_value_in;
         end else if (r_load_pending) begin
            w_shadow_nxt = r_pending;
         end
         w_load_pending_nxt = 1'b0;
      end else if (i_load) begin
         w_pending_nxt      = i_value_in;
         w_load_pending_nxt = 1'b1;
      end
   end

   // Outputs are derived from next state so they are valid on the first SHOW cycle.
   always_comb begin
      w_digit       = '0;
      w_digit_blank = 1'b0;
      w_zero_above  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero_above = w_zero_above && (w_shadow_nxt[i*BCD_W +: BCD_W] == '0);
         if (IdxW'(i) == w_idx_nxt) begin
            w_digit       = w_shadow_nxt[i*BCD_W +: BCD_W];
            w_digit_blank = i_lz_blank_en && w_zero_above && (i != 0);
         end
      end
   end

   seven_segment_decoder u_decoder (
      .i_bcd (w_digit),
      .o_seg (w_dec_seg)
   );

   always_comb begin
      w_anode_nxt    = '0;
      w_segments_nxt = SEG_OFF;
      if (w_state_nxt == StShow) begin
         w_anode_nxt    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_nxt;
         w_segments_nxt = w_digit_blank ? SEG_OFF : w_dec_seg;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= StIdle;
         r_cnt          <= '0;
         r_idx          <= '0;
         r_shadow       <= '0;
         r_pending      <= '0;
         r_load_pending <= 1'b0;
         r_anode        <= '0;
         r_segments     <= SEG_OFF;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_idx          <= w_idx_nxt;
         r_shadow       <= w_shadow_nxt;
         r_pending      <= w_pending_nxt;
         r_load_pending <= w_load_pending_nxt;
         r_anode        <= w_anode_nxt;
         r_segments     <= w_segments_nxt;
      end
   end

   assign o_anode        = r_anode;
   assign o_segments     = r_segments;
   assign o_load_pending = r_load_pending;
   assign o_frame_done   = w_frame_end && !i_rst;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed and randomized bench for seven_seg_scan_ctrl against a timeline-based reference model.
module tb_seven_seg_scan_ctrl;

   localparam int unsigned N     = 4;
   localparam int unsigned P     = 8;
   localparam int unsigned B     = 2;
   localparam int unsigned FRAME = N * P;

   logic        clk = 1'b0;
   logic        rst, en, ld, lz;
   logic [15:0] val;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic        lp, fd;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   // Model: scan position is just a cycle count since the scan started.
   bit          m_on;
   int unsigned m_t;
   logic [15:0] m_shadow, m_pv;
   bit          m_pend;
   bit          cur_lz;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS   (N),
      .PRESCALE     (P),
      .BLANK_CYCLES (B)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_enable       (en),
      .i_load         (ld),
      .i_value_in     (val),
      .i_lz_blank_en  (lz),
      .o_anode        (anode),
      .o_segments     (seg),
      .o_load_pending (lp),
      .o_frame_done   (fd)
   );

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit e, input bit l, input logic [15:0] v, input bit z);
      int unsigned slot, k;
      bit          cap;
      logic [3:0]  ea;
      logic [6:0]  es;
      logic [3:0]  nib;
      rst = r; en = e; ld = l; val = v; lz = z;
      #1;
      chk("frame_done", {15'b0, fd}, {15'b0, (!r && e && m_on && m_t == FRAME - 1)});
      @(posedge clk);
      if (r) begin
         m_on = 0; m_t = 0; m_shadow = '0; m_pv = '0; m_pend = 0;
      end else begin
         cap = e && (!m_on || m_t == FRAME - 1);
         if (cap) begin
            if (l) m_shadow = v;
            else if (m_pend) m_shadow = m_pv;
            m_pend = 0;
         end else if (l) begin
            m_pv = v;
            m_pend = 1;
         end
         if (!e) begin
            m_on = 0; m_t = 0;
         end else if (!m_on) begin
            m_on = 1; m_t = 0;
         end else begin
            m_t = (m_t + 1) % FRAME;
         end
      end
      slot = m_t / P;
      k    = m_t % P;
      ea   = '0;
      es   = '0;
      if (m_on && k >= B) begin
         ea  = 4'(1 << slot);
         nib = m_shadow[4*slot +: 4];
         if (!(z && slot > 0 && (m_shadow >> (4 * slot)) == 16'h0)) es = ref_seg(nib);
      end
      #1;
      chk("anode", {12'b0, anode}, {12'b0, ea});
      chk("segments", {9'b0, seg}, {9'b0, es});
      chk("load_pending", {15'b0, lp}, {15'b0, m_pend});
   endtask

   task automatic run(input int unsigned n);
      for (int i = 0; i < int'(n); i++) step(0, 1, 0, 16'h0, cur_lz);
   endtask

   task automatic run_to(input int unsigned t);
      for (int i = 0; i < int'(2 * FRAME) && !(m_on && m_t == t); i++) step(0, 1, 0, 16'h0, cur_lz);
      chk("reach_pos", 16'(m_on && m_t == t), 16'h1);
   endtask

   initial begin
      rst = 1; en = 0; ld = 0; val = '0; lz = 0; cur_lz = 0;
      m_on = 0; m_t = 0; m_shadow = '0; m_pv = '0; m_pend = 0;
      @(posedge clk);
      #1;
      chk("rst_anode", {12'b0, anode}, 16'h0);
      chk("rst_seg", {9'b0, seg}, 16'h0);
      chk("rst_lp", {15'b0, lp}, 16'h0);
      chk("rst_fd", {15'b0, fd}, 16'h0);
      step(1, 0, 0, 16'h0, 0);

      // First frame shows the reset shadow; 1234 appears after the boundary.
      run(5);
      step(0, 1, 1, 16'h1234, cur_lz);
      run(2 * FRAME + 8);

      // Leading-zero blanking.
      cur_lz = 1;
      step(0, 1, 1, 16'h0070, cur_lz);
      run(2 * FRAME);
      step(0, 1, 1, 16'h0000, cur_lz);
      run(2 * FRAME);
      cur_lz = 0;

      // Two loads mid-frame, last wins.
      run_to(10);
      step(0, 1, 1, 16'h1111, cur_lz);
      run(5);
      step(0, 1, 1, 16'h2222, cur_lz);
      run(2 * FRAME);

      // Load coinciding with the frame boundary goes straight to the shadow.
      run_to(FRAME - 1);
      step(0, 1, 1, 16'h5678, cur_lz);
      run(FRAME + 4);

      // Drop enable mid-SHOW of digit 2, then restart.
      run_to(2 * P + 4);
      step(0, 0, 0, 16'h0, cur_lz);
      step(0, 0, 0, 16'h0, cur_lz);
      run(FRAME + 4);

      // Reset with a pending load, then an out-of-range nibble.
      run_to(P + 3);
      step(0, 1, 1, 16'h9999, cur_lz);
      step(1, 1, 0, 16'h0, cur_lz);
      run(3);
      step(0, 1, 1, 16'h3A01, cur_lz);
      run(2 * FRAME);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         bit          r, e, l;
         logic [15:0] v;
         r = ($urandom_range(0, 199) == 0);
         e = ($urandom_range(0, 59) != 0);
         l = ($urandom_range(0, 11) == 0);
         v = 16'($urandom);
         if ($urandom_range(0, 2) == 0) v = v & 16'h00F7;
         if ($urandom_range(0, 63) == 0) cur_lz = !cur_lz;
         step(r, e, l, v, cur_lz);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
